// File: rtl/ave_filter_ctrl.sv
// Sequencer for the N-tap moving-average filter on the DHT11 data path:
// clears the filter, tracks warm-up fill, publishes averages and runs a sample watchdog.
module ave_filter_ctrl #(
    parameter int AVE_DATA_NUM = 8,
    parameter int DATA_W       = 20,
    parameter int TIMEOUT_CYC  = 150_000_000,
    parameter int TO_W         = 28
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              raw_vld,
    input  logic [DATA_W-1:0] raw_data,
    input  logic              flush,
    output logic              filt_en,
    output logic [DATA_W-1:0] filt_din,
    output logic              filt_clr,
    input  logic [DATA_W-1:0] filt_dout,
    output logic [DATA_W-1:0] ave_data,
    output logic              ave_vld,
    output logic              warm,
    output logic              timeout
);

    localparam int                CNT_W   = $clog2(AVE_DATA_NUM) + 1;
    localparam logic [CNT_W-1:0]  FULL    = CNT_W'(AVE_DATA_NUM);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(AVE_DATA_NUM - 1);
    localparam logic [TO_W-1:0]   WD_LAST = TO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ST_CLR  = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]        state_q,    state_d;
    logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic [TO_W-1:0]   wd_cnt_q,   wd_cnt_d;
    logic              filt_en_q,  filt_en_d;
    logic [DATA_W-1:0] filt_din_q, filt_din_d;
    logic              full1_q,    full1_d;
    logic              s2_vld_q,   s2_vld_d;
    logic [DATA_W-1:0] ave_data_q, ave_data_d;
    logic              ave_vld_q,  ave_vld_d;
    logic              filt_clr_q, filt_clr_d;
    logic              warm_q,     warm_d;
    logic              timeout_q,  timeout_d;

    logic active, accept, expire, enter_clr;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        active = (state_q == ST_FILL) || (state_q == ST_RUN);
        accept = active && raw_vld && !flush;
        expire = active && !accept && (wd_cnt_q == WD_LAST);

        state_d = state_q;
        case (state_q)
            ST_CLR:  state_d = ST_FILL;
            ST_FILL: if (accept && fill_cnt_q == FULL_M1) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_CLR;
        endcase
        if (flush || expire) state_d = ST_CLR;
        enter_clr = (state_d == ST_CLR);

        fill_cnt_d = fill_cnt_q;
        if (enter_clr)                        fill_cnt_d = '0;
        else if (accept && fill_cnt_q != FULL) fill_cnt_d = fill_cnt_q + CNT_W'(1);

        // Watchdog only counts in FILL/RUN; leaving CLR restarts it from zero.
        wd_cnt_d = wd_cnt_q + TO_W'(1);
        if (accept || !active || enter_clr) wd_cnt_d = '0;

        filt_en_d  = accept;
        filt_din_d = accept ? raw_data : filt_din_q;
        full1_d    = accept && (fill_cnt_d == FULL);

        // Entering CLR kills every result still travelling toward ave_vld.
        s2_vld_d   = filt_en_q && full1_q && !enter_clr;
        ave_vld_d  = s2_vld_q && !enter_clr;
        ave_data_d = ave_vld_d ? filt_dout : ave_data_q;

        // The clear pulse trails the CLR state so that reset itself keeps it low.
        filt_clr_d = (state_q == ST_CLR);
        warm_d     = (state_d != ST_RUN);
        timeout_d  = expire;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_CLR;
            fill_cnt_q <= '0;
            wd_cnt_q   <= '0;
            filt_en_q  <= 1'b0;
            filt_din_q <= '0;
            full1_q    <= 1'b0;
            s2_vld_q   <= 1'b0;
            ave_data_q <= '0;
            ave_vld_q  <= 1'b0;
            filt_clr_q <= 1'b0;
            warm_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            filt_en_q  <= filt_en_d;
            filt_din_q <= filt_din_d;
            full1_q    <= full1_d;
            s2_vld_q   <= s2_vld_d;
            ave_data_q <= ave_data_d;
            ave_vld_q  <= ave_vld_d;
            filt_clr_q <= filt_clr_d;
            warm_q     <= warm_d;
            timeout_q  <= timeout_d;
        end
    end

    assign filt_en  = filt_en_q;
    assign filt_din = filt_din_q;
    assign filt_clr = filt_clr_q;
    assign ave_data = ave_data_q;
    assign ave_vld  = ave_vld_q;
    assign warm     = warm_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_ave_filter_ctrl.sv
// Bench for ave_filter_ctrl: a behavioural moving-average filter drives filt_dout and a
// sample-history / event-queue reference model predicts every output each cycle.
module tb_ave_filter_ctrl;

    localparam int N   = 8;
    localparam int LG  = 3;
    localparam int DW  = 20;
    localparam int TO  = 50;
    localparam int TOW = 8;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          raw_vld   = 1'b0;
    logic [DW-1:0] raw_data  = '0;
    logic          flush     = 1'b0;
    logic          filt_en, filt_clr, ave_vld, warm, timeout;
    logic [DW-1:0] filt_din, filt_dout, ave_data;

    ave_filter_ctrl #(
        .AVE_DATA_NUM(N), .DATA_W(DW), .TIMEOUT_CYC(TO), .TO_W(TOW)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .raw_vld(raw_vld), .raw_data(raw_data),
        .flush(flush), .filt_en(filt_en), .filt_din(filt_din), .filt_clr(filt_clr),
        .filt_dout(filt_dout), .ave_data(ave_data), .ave_vld(ave_vld), .warm(warm),
        .timeout(timeout)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural filter: N-deep shift register with a registered running sum.
    logic [DW-1:0]   taps [N];
    logic [DW+LG-1:0] fsum;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fsum <= '0;
            for (int i = 0; i < N; i++) taps[i] <= '0;
        end else if (filt_clr) begin
            fsum <= '0;
            for (int i = 0; i < N; i++) taps[i] <= '0;
        end else if (filt_en) begin
            fsum    <= fsum + (DW+LG)'(filt_din) - (DW+LG)'(taps[N-1]);
            taps[0] <= filt_din;
            for (int i = 1; i < N; i++) taps[i] <= taps[i-1];
        end
    end
    assign filt_dout = fsum[DW+LG-1:LG];

    // Reference model state
    typedef struct { int due; logic [DW-1:0] val; } ev_t;
    ev_t           evq [$];
    int unsigned   hist [$];
    bit            m_clr;
    int            idle;
    int            cyc;
    logic          e_en, e_clr, e_warm, e_to, e_vld;
    logic [DW-1:0] e_din, e_ave;

    int tests = 0;
    int fails = 0;
    int n_en = 0, n_vld = 0, n_to = 0;
    int b_en, b_vld, b_to;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clr = 1'b1;
        idle  = 0;
        hist.delete();
        evq.delete();
        e_en = 0; e_clr = 0; e_warm = 0; e_to = 0; e_vld = 0;
        e_din = '0; e_ave = '0;
    endtask

    // Predicts the outputs seen after the coming clock edge.
    task automatic model_step(input logic v, input logic [DW-1:0] d, input logic f);
        bit     acc, exp_hit;
        longint s;
        e_en = 0; e_clr = 0; e_to = 0; e_vld = 0;
        if (m_clr) begin
            e_clr  = 1;
            e_warm = 1;
            if (!f) begin
                m_clr = 0;
                idle  = 0;
            end
        end else begin
            acc     = v && !f;
            exp_hit = !acc && (idle == TO - 1);
            if (acc) begin
                hist.push_back(32'(d));
                if (hist.size() > N) void'(hist.pop_front());
                e_en  = 1;
                e_din = d;
                idle  = 0;
                if (hist.size() == N) begin
                    s = 0;
                    foreach (hist[i]) s += longint'(hist[i]);
                    evq.push_back('{due: cyc + 3, val: DW'(s / N)});
                end
            end else begin
                idle++;
            end
            if (f || exp_hit) begin
                m_clr = 1;
                hist.delete();
                evq.delete();
                e_to = exp_hit;
            end
            e_warm = m_clr || (hist.size() < N);
        end
        if (evq.size() > 0 && evq[0].due == cyc + 1) begin
            e_vld = 1;
            e_ave = evq[0].val;
            void'(evq.pop_front());
        end
    endtask

    task automatic check_outputs();
        check("filt_en", 32'(filt_en), 32'(e_en));
        if (e_en) check("filt_din", 32'(filt_din), 32'(e_din));
        check("filt_clr", 32'(filt_clr), 32'(e_clr));
        check("warm", 32'(warm), 32'(e_warm));
        check("timeout", 32'(timeout), 32'(e_to));
        check("ave_vld", 32'(ave_vld), 32'(e_vld));
        check("ave_data", 32'(ave_data), 32'(e_ave));
    endtask

    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic f);
        raw_vld  = v;
        raw_data = d;
        flush    = f;
        model_step(v, d, f);
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
        if (filt_en) n_en++;
        if (ave_vld) n_vld++;
        if (timeout) n_to++;
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) cycle(1'b0, '0, 1'b0);
    endtask

    task automatic fill_window(input logic [DW-1:0] base);
        for (int i = 0; i < N; i++) cycle(1'b1, base + DW'(i), 1'b0);
    endtask

    task automatic mark();
        b_en = n_en; b_vld = n_vld; b_to = n_to;
    endtask

    initial begin
        cyc = 0;
        model_reset();

        // 1: reset state, then slow warm-up with constant data
        repeat (2) @(negedge sys_clk);
        check_outputs();
        sys_rst_n = 1'b1;
        idle_cycles(1);
        check("t1_clr_after_reset", 32'(filt_clr), 32'd1);
        mark();
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, DW'(100), 1'b0);
            if (i == N - 1) check("t1_warm_low", 32'(warm), 32'd0);
            else            check("t1_warm_high", 32'(warm), 32'd1);
            idle_cycles(9);
        end
        check("t1_en_count", 32'(n_en - b_en), 32'(N));
        check("t1_vld_count", 32'(n_vld - b_vld), 32'd1);
        check("t1_ave_data", 32'(ave_data), 32'd100);

        // 2: back-to-back samples with a full window
        mark();
        for (int i = 0; i < 16; i++) cycle(1'b1, DW'(i), 1'b0);
        idle_cycles(3);
        check("t2_en_count", 32'(n_en - b_en), 32'd16);
        check("t2_vld_count", 32'(n_vld - b_vld), 32'd16);

        // 3: flush after 5 accepts, coincident with a sample
        cycle(1'b0, '0, 1'b1);
        idle_cycles(2);
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0);
        mark();
        cycle(1'b1, DW'(77), 1'b1);
        check("t3_warm", 32'(warm), 32'd1);
        idle_cycles(1);
        check("t3_clr", 32'(filt_clr), 32'd1);
        for (int i = 0; i < N - 1; i++) cycle(1'b1, DW'($urandom), 1'b0);
        idle_cycles(4);
        check("t3_no_vld", 32'(n_vld - b_vld), 32'd0);
        check("t3_dropped", 32'(n_en - b_en), 32'(N - 1));
        cycle(1'b1, DW'($urandom), 1'b0);
        idle_cycles(3);
        check("t3_vld_after_8", 32'(n_vld - b_vld), 32'd1);

        // 4: watchdog expiry with a full window
        fill_window(DW'(500));
        mark();
        idle_cycles(TO + 10);
        check("t4_timeouts", 32'(n_to - b_to), 32'd1);
        check("t4_warm", 32'(warm), 32'd1);

        // 5: sample on the expiry cycle wins over the watchdog
        fill_window(DW'(1000));
        idle_cycles(TO - 1);
        mark();
        cycle(1'b1, DW'(4321), 1'b0);
        idle_cycles(3);
        check("t5_timeouts", 32'(n_to - b_to), 32'd0);
        check("t5_vld", 32'(n_vld - b_vld), 32'd1);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom % 2), DW'($urandom), 1'($urandom % 32 == 0));
        idle_cycles(4);

        // 6: reset between filt_en and ave_vld
        fill_window(DW'(9000));
        idle_cycles(4);
        mark();
        cycle(1'b1, DW'(12345), 1'b0);
        check("t6_en", 32'(filt_en), 32'd1);
        sys_rst_n = 1'b0;
        raw_vld   = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
        check_outputs();
        sys_rst_n = 1'b1;
        idle_cycles(1);
        check("t6_clr_after_release", 32'(filt_clr), 32'd1);
        idle_cycles(4);
        check("t6_no_vld", 32'(n_vld - b_vld), 32'd0);
        check("t6_ave_data", 32'(ave_data), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
